// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: runs the EX/MEM load/store against a multi-cycle
// data memory, stalls upstream while in flight and drives the MEM/WB write enable.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wr_data_in,
    input  logic        mem_busy,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] read_data_out,
    output logic        wb_en,
    output logic        bubble_out,
    output logic        stall_out,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             wr_q, wr_d;
    logic             acc;
    logic             timeout_hit;

    assign acc         = valid_in & (mem_read_in | mem_write_in);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        stall_out  = 1'b0;
        wb_en      = 1'b1;
        bubble_out = 1'b0;
        mem_req    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    stall_out  = 1'b1;
                    wb_en      = 1'b0;
                    bubble_out = 1'b1;
                    // Odd addresses fault before any memory traffic is generated.
                    if (addr_in[0]) begin
                        state_d = S_ERR;
                    end else if (!mem_busy) begin
                        addr_d  = addr_in;
                        wdata_d = wr_data_in;
                        wr_d    = mem_write_in;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_out  = 1'b1;
                wb_en      = 1'b0;
                bubble_out = 1'b1;
                mem_req    = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                stall_out  = 1'b1;
                wb_en      = 1'b0;
                bubble_out = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                // A completion on the final allowed cycle beats the timeout.
                if (mem_done) begin
                    if (!wr_q) rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                stall_out  = 1'b1;
                wb_en      = 1'b0;
                bubble_out = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_wr        = wr_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign read_data_out = rdata_q;
    assign err           = (state_q == S_ERR);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// back-to-back transactions checked against a transaction-level latency model.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [15:0] addr_in = '0, wr_data_in = '0, mem_rdata = '0;
    logic        mem_busy = 1'b0, mem_done = 1'b0;
    logic        mem_req, mem_wr, wb_en, bubble_out, stall_out, err;
    logic [15:0] mem_addr, mem_wdata, read_data_out;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_rd;

    int          o_stall, o_req, o_req_cyc, o_done_cyc, o_addr_bad, o_hs_bad;
    logic        o_err, o_wr_at_req;
    logic [15:0] o_wdata_at_req, o_rdata;

    mem_stage_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .addr_in(addr_in), .wr_data_in(wr_data_in),
        .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .read_data_out(read_data_out), .wb_en(wb_en), .bubble_out(bubble_out),
        .stall_out(stall_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0;
        mem_busy = 0; mem_done = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        exp_rd = 16'h0000;
    endtask

    // Drives one access, acting as the memory: busy for the first `busy` cycles,
    // mem_done `n` cycles after the observed request. Records what the DUT did.
    task automatic run_access(input logic ld, input logic [15:0] a, input logic [15:0] wd,
                              input int busy, input int n, input logic [15:0] rd);
        o_stall = 0; o_req = 0; o_req_cyc = -1; o_done_cyc = -1;
        o_addr_bad = 0; o_hs_bad = 0; o_err = 0; o_wr_at_req = 1'bx;
        o_wdata_at_req = 'x; o_rdata = 'x;
        valid_in = 1; mem_read_in = ld; mem_write_in = !ld; addr_in = a; wr_data_in = wd;
        for (int c = 0; c < 400; c++) begin
            mem_busy  = (c < busy) ? 1'b1 : (o_req_cyc >= 0 && $urandom_range(0, 1) == 1);
            mem_done  = (o_req_cyc >= 0 && c == o_req_cyc + n) ||
                        (c < busy && $urandom_range(0, 3) == 0);
            mem_rdata = (o_req_cyc >= 0 && c == o_req_cyc + n) ? rd : 16'($urandom);
            @(negedge clk);
            if (stall_out) o_stall++;
            if (bubble_out !== stall_out || wb_en === stall_out) o_hs_bad++;
            if (mem_req === 1'b1) begin
                o_req++;
                if (o_req_cyc < 0) begin
                    o_req_cyc = c; o_wr_at_req = mem_wr; o_wdata_at_req = mem_wdata;
                end
            end
            if (o_req_cyc >= 0 && mem_addr !== a) o_addr_bad++;
            if (err) o_err = 1;
            if (wb_en === 1'b1) begin
                o_done_cyc = c;
                o_rdata = read_data_out;
                break;
            end
            tick();
        end
        if (o_done_cyc >= 0) tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        checks++; if (read_data_out !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", read_data_out); end
        checks++; if (mem_req !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL reset_req_wr got=%b%b exp=00", mem_req, mem_wr); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_latched got=%h/%h exp=0000/0000", mem_addr, mem_wdata); end
        checks++; if (stall_out !== 1'b0 || wb_en !== 1'b1 || bubble_out !== 1'b0) begin failures++; $display("FAIL reset_hs got=s%b w%b b%b exp=s0 w1 b0", stall_out, wb_en, bubble_out); end
        tick();
        rst_n = 1;
        exp_rd = 16'h0000;
    endtask

    task automatic test_alu();
        int bad = 0;
        for (int c = 0; c < 8; c++) begin
            valid_in = 1; mem_read_in = 0; mem_write_in = 0;
            addr_in = 16'($urandom); mem_busy = 1'($urandom); mem_done = 1'($urandom);
            @(negedge clk);
            if (wb_en !== 1'b1 || stall_out !== 1'b0 || bubble_out !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) bad++;
            tick();
        end
        idle_inputs();
        checks++; if (bad != 0) begin failures++; $display("FAIL alu_passthru bad_cycles=%0d exp=0", bad); end
        checks++; if (read_data_out !== exp_rd) begin failures++; $display("FAIL alu_rdata got=%h exp=%h", read_data_out, exp_rd); end
    endtask

    task automatic test_load();
        run_access(1'b1, 16'h0010, 16'h5555, 0, 2, 16'hBEEF);
        exp_rd = 16'hBEEF;
        checks++; if (o_stall != 4) begin failures++; $display("FAIL load_stall got=%0d exp=4", o_stall); end
        checks++; if (o_done_cyc != 4) begin failures++; $display("FAIL load_done_cyc got=%0d exp=4", o_done_cyc); end
        checks++; if (o_req != 1 || o_req_cyc != 1) begin failures++; $display("FAIL load_req got=%0d@%0d exp=1@1", o_req, o_req_cyc); end
        checks++; if (o_rdata !== 16'hBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=beef", o_rdata); end
        checks++; if (o_wr_at_req !== 1'b0) begin failures++; $display("FAIL load_wr got=%b exp=0", o_wr_at_req); end
        checks++; if (o_addr_bad != 0 || o_hs_bad != 0) begin failures++; $display("FAIL load_hold addr_bad=%0d hs_bad=%0d exp=0/0", o_addr_bad, o_hs_bad); end
    endtask

    task automatic test_store();
        run_access(1'b0, 16'h0020, 16'h1234, 0, 1, 16'h7777);
        checks++; if (o_req != 1) begin failures++; $display("FAIL store_req_count got=%0d exp=1", o_req); end
        checks++; if (o_wr_at_req !== 1'b1) begin failures++; $display("FAIL store_wr got=%b exp=1", o_wr_at_req); end
        checks++; if (o_wdata_at_req !== 16'h1234) begin failures++; $display("FAIL store_wdata got=%h exp=1234", o_wdata_at_req); end
        checks++; if (o_rdata !== exp_rd) begin failures++; $display("FAIL store_rdata_hold got=%h exp=%h", o_rdata, exp_rd); end
        checks++; if (o_stall != 3 || o_done_cyc != 3) begin failures++; $display("FAIL store_latency got=%0d/%0d exp=3/3", o_stall, o_done_cyc); end
    endtask

    task automatic test_busy();
        run_access(1'b1, 16'h0100, 16'h0, 3, 2, 16'hCAFE);
        exp_rd = 16'hCAFE;
        checks++; if (o_req_cyc != 4 || o_req != 1) begin failures++; $display("FAIL busy_req got=%0d@%0d exp=1@4", o_req, o_req_cyc); end
        checks++; if (o_stall != 7) begin failures++; $display("FAIL busy_stall got=%0d exp=7", o_stall); end
        checks++; if (o_rdata !== 16'hCAFE) begin failures++; $display("FAIL busy_rdata got=%h exp=cafe", o_rdata); end
    endtask

    task automatic test_unaligned();
        int bad = 0;
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; addr_in = 16'h0011;
        @(negedge clk);
        checks++; if (err !== 1'b0 || stall_out !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL unal_first got=e%b s%b r%b exp=e0 s1 r0", err, stall_out, mem_req); end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 3) idle_inputs();
            mem_done = (c == 5);
            @(negedge clk);
            if (err !== 1'b1 || stall_out !== 1'b1 || wb_en !== 1'b0 || bubble_out !== 1'b1 || mem_req !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL unal_stuck bad_cycles=%0d exp=0", bad); end
        tick();
        idle_inputs();
        rst_n = 0;
        #1;
        checks++; if (err !== 1'b0 || stall_out !== 1'b0) begin failures++; $display("FAIL unal_reset got=e%b s%b exp=e0 s0", err, stall_out); end
        tick();
        rst_n = 1;
        exp_rd = 16'h0000;
    endtask

    task automatic test_timeout();
        int first_err = -1;
        int reqs = 0;
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; addr_in = 16'h0040;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) reqs++;
            if (err === 1'b1 && first_err < 0) first_err = c;
            tick();
        end
        checks++; if (first_err != 66) begin failures++; $display("FAIL timeout_err_cyc got=%0d exp=66", first_err); end
        checks++; if (reqs != 1) begin failures++; $display("FAIL timeout_req got=%0d exp=1", reqs); end
        do_reset();
        run_access(1'b1, 16'h0042, 16'h0, 0, 64, 16'h600D);
        exp_rd = 16'h600D;
        checks++; if (o_err !== 1'b0 || o_done_cyc != 66) begin failures++; $display("FAIL timeout_edge got=err%b done@%0d exp=err0 done@66", o_err, o_done_cyc); end
        checks++; if (o_rdata !== 16'h600D) begin failures++; $display("FAIL timeout_edge_rdata got=%h exp=600d", o_rdata); end
    endtask

    task automatic test_reset_mid();
        valid_in = 1; mem_read_in = 1; mem_write_in = 0; addr_in = 16'h0080;
        tick(); tick(); tick();
        @(negedge clk);
        checks++; if (stall_out !== 1'b1 || mem_addr !== 16'h0080) begin failures++; $display("FAIL mid_pre got=s%b a%h exp=s1 a0080", stall_out, mem_addr); end
        tick();
        idle_inputs();
        rst_n = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall_out !== 1'b0 || wb_en !== 1'b1 || mem_addr !== 16'h0) begin failures++; $display("FAIL mid_reset got=r%b s%b w%b a%h exp=r0 s0 w1 a0000", mem_req, stall_out, wb_en, mem_addr); end
        tick();
        rst_n = 1;
        exp_rd = 16'h0000;
        mem_done = 1; mem_rdata = 16'hAAAA;
        tick();
        mem_done = 0;
        @(negedge clk);
        checks++; if (read_data_out !== 16'h0 || mem_req !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_late_done got=d%h r%b e%b exp=d0000 r0 e0", read_data_out, mem_req, err); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 24; t++) begin
            logic        ld;
            logic [15:0] a, wd, rd, want_rd;
            int          b, n;
            ld = 1'($urandom);
            a  = 16'($urandom) & 16'hFFFE;
            wd = 16'($urandom);
            rd = 16'($urandom);
            b  = $urandom_range(0, 3);
            n  = $urandom_range(1, 8);
            run_access(ld, a, wd, b, n, rd);
            want_rd = ld ? rd : exp_rd;
            exp_rd = want_rd;
            checks++; if (o_done_cyc != b + n + 2) begin failures++; $display("FAIL b2b_done_cyc t=%0d got=%0d exp=%0d", t, o_done_cyc, b + n + 2); end
            checks++; if (o_stall != b + n + 2) begin failures++; $display("FAIL b2b_stall t=%0d got=%0d exp=%0d", t, o_stall, b + n + 2); end
            checks++; if (o_req != 1 || o_req_cyc != b + 1) begin failures++; $display("FAIL b2b_req t=%0d got=%0d@%0d exp=1@%0d", t, o_req, o_req_cyc, b + 1); end
            checks++; if (o_rdata !== want_rd) begin failures++; $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, o_rdata, want_rd); end
            checks++; if (o_wr_at_req !== !ld || o_wdata_at_req !== wd) begin failures++; $display("FAIL b2b_wr t=%0d got=%b/%h exp=%b/%h", t, o_wr_at_req, o_wdata_at_req, !ld, wd); end
            checks++; if (o_addr_bad != 0 || o_hs_bad != 0 || o_err !== 1'b0) begin failures++; $display("FAIL b2b_misc t=%0d addr_bad=%0d hs_bad=%0d err=%b exp=0/0/0", t, o_addr_bad, o_hs_bad, o_err); end
        end
    endtask

    initial begin
        exp_rd = 16'h0000;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_alu();
        test_busy();
        test_unaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
